// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns a one-at-a-time command/response handshake into
// AXI4-Lite master transactions, with an optional watchdog that freezes the
// block when a slave never completes a transaction.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command, o_cmd_ready high
// WR_AW_W | AW and W valids raised, each dropped on its own handshake
// WR_B    | both write handshakes done, waiting for the B beat
// RD_AR   | AR valid raised, waiting for arready
// RD_R    | waiting for the R beat
// RSP     | response presented until i_rsp_ready
// HUNG    | watchdog fired; everything frozen until rst
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_data,
  input  logic [3:0]            i_cmd_strb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [31:0]           o_rsp_data,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_rsp_timeout,
  output logic                  o_hung,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [31:0]           i_rdata,
  input  logic [1:0]            i_rresp
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_RSP     = 3'd5,
    S_HUNG    = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_nxt;
  logic             in_flight;
  logic             xfer_done;
  logic             wd_expire;

  // Command acceptance is decoded straight from state so it needs no extra cycle.
  assign o_cmd_ready = (state == S_IDLE) && !rst;

  // Completion of the awaited step in each in-flight state, and watchdog expiry.
  // A completion on the limit cycle wins over the timeout.
  always_comb begin
    in_flight  = 1'b0;
    xfer_done  = 1'b0;
    wd_cnt_nxt = wd_cnt + CNT_W'(1);
    case (state)
      S_WR_AW_W: begin
        in_flight = 1'b1;
        xfer_done = (!o_awvalid || i_awready) && (!o_wvalid || i_wready);
      end
      S_WR_B: begin
        in_flight = 1'b1;
        xfer_done = i_bvalid;
      end
      S_RD_AR: begin
        in_flight = 1'b1;
        xfer_done = i_arready;
      end
      S_RD_R: begin
        in_flight = 1'b1;
        xfer_done = i_rvalid;
      end
      default: begin
        in_flight = 1'b0;
        xfer_done = 1'b0;
      end
    endcase
    wd_expire = (TIMEOUT_CYCLES > 0) && in_flight && !xfer_done && (wd_cnt_nxt == CNT_LIMIT);
  end

  // Main sequencer: state, watchdog counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wd_cnt        <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_write   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= '0;
      o_rsp_timeout <= 1'b0;
      o_hung        <= 1'b0;
      o_awvalid     <= 1'b0;
      o_awaddr      <= '0;
      o_wvalid      <= 1'b0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_araddr      <= '0;
      o_rready      <= 1'b0;
    end else begin
      if (in_flight) wd_cnt <= wd_cnt_nxt;
      if (wd_expire) begin
        // Abandon the bus entirely; a half-done AXI transaction cannot be resumed.
        o_awvalid     <= 1'b0;
        o_wvalid      <= 1'b0;
        o_bready      <= 1'b0;
        o_arvalid     <= 1'b0;
        o_rready      <= 1'b0;
        o_awaddr      <= '0;
        o_araddr      <= '0;
        o_wdata       <= '0;
        o_wstrb       <= '0;
        o_rsp_valid   <= 1'b1;
        o_rsp_data    <= '0;
        o_rsp_resp    <= 2'b11;
        o_rsp_timeout <= 1'b1;
        o_hung        <= 1'b1;
        state         <= S_RSP;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_cmd_valid) begin
              wd_cnt      <= '0;
              o_rsp_write <= i_cmd_write;
              if (i_cmd_write) begin
                o_awaddr  <= i_cmd_addr;
                o_wdata   <= i_cmd_data;
                o_wstrb   <= i_cmd_strb;
                o_awvalid <= 1'b1;
                o_wvalid  <= 1'b1;
                state     <= S_WR_AW_W;
              end else begin
                o_araddr  <= i_cmd_addr;
                o_arvalid <= 1'b1;
                state     <= S_RD_AR;
              end
            end
          end
          S_WR_AW_W: begin
            if (i_awready) o_awvalid <= 1'b0;
            if (i_wready)  o_wvalid  <= 1'b0;
            if (xfer_done) begin
              o_bready <= 1'b1;
              state    <= S_WR_B;
            end
          end
          S_WR_B: begin
            if (i_bvalid) begin
              o_bready      <= 1'b0;
              o_rsp_valid   <= 1'b1;
              o_rsp_data    <= '0;
              o_rsp_resp    <= i_bresp;
              o_rsp_timeout <= 1'b0;
              state         <= S_RSP;
            end
          end
          S_RD_AR: begin
            if (i_arready) begin
              o_arvalid <= 1'b0;
              o_rready  <= 1'b1;
              state     <= S_RD_R;
            end
          end
          S_RD_R: begin
            if (i_rvalid) begin
              o_rready      <= 1'b0;
              o_rsp_valid   <= 1'b1;
              o_rsp_data    <= i_rdata;
              o_rsp_resp    <= i_rresp;
              o_rsp_timeout <= 1'b0;
              state         <= S_RSP;
            end
          end
          S_RSP: begin
            if (i_rsp_ready) begin
              o_rsp_valid <= 1'b0;
              state       <= o_rsp_timeout ? S_HUNG : S_IDLE;
            end
          end
          S_HUNG: begin
            state <= S_HUNG;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: table vectors, randomized transactions
// against a latency/response model, and hand sequences for reset and watchdog.
module tb_axi_lite_cmd_master;
  localparam int AW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_data;
  logic [3:0]    i_cmd_strb;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_write, o_rsp_timeout, o_hung;
  logic [31:0]   o_rsp_data;
  logic [1:0]    o_rsp_resp;
  logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [31:0]   o_wdata, i_rdata;
  logic [3:0]    o_wstrb;
  logic [1:0]    i_bresp, i_rresp;
  logic          o_arvalid, i_arready, i_rvalid, o_rready;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_hung(o_hung),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd, wd, bd, ard, rd;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_aw_hi, exp_w_hi;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave configuration and monitor state
  int          aw_d, w_d, b_d, ar_d, r_d;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  bit          aw_got, w_got, ar_got, b_fire, r_fire;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int          aw_hi, w_hi, ar_hi;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int          proto_err = 0;
  logic [15:0] seen_awaddr, seen_araddr;
  logic [31:0] seen_wdata;
  logic [3:0]  seen_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI-Lite slave: configurable per-channel wait cycles, drives at negedge.
  initial begin
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    i_arready = 0; i_rvalid = 0; i_rdata = 0; i_rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        i_arready = 0; i_rvalid = 0; i_rdata = 0; i_rresp = 0;
        b_fire = 0; r_fire = 0;
      end else begin
        if (o_bready && !(aw_got && w_got)) proto_err++;
        if (o_rready && !ar_got) proto_err++;
        if (b_fire) begin i_bvalid = 0; b_fire = 0; end
        else if (aw_got && w_got && b_hs == 0 && !i_bvalid) begin
          if (b_wait >= b_d) begin i_bvalid = 1; i_bresp = s_bresp; end
          else b_wait++;
        end
        if (i_bvalid && o_bready) begin b_fire = 1; b_hs++; end
        if (r_fire) begin i_rvalid = 0; r_fire = 0; end
        else if (ar_got && r_hs == 0 && !i_rvalid) begin
          if (r_wait >= r_d) begin i_rvalid = 1; i_rdata = s_rdata; i_rresp = s_rresp; end
          else r_wait++;
        end
        if (i_rvalid && o_rready) begin r_fire = 1; r_hs++; end
        if (o_awvalid) aw_hi++;
        if (o_awvalid && !aw_got) begin
          if (aw_wait >= aw_d) begin
            i_awready = 1; aw_got = 1; aw_hs++; seen_awaddr = o_awaddr;
          end else begin i_awready = 0; aw_wait++; end
        end else begin
          i_awready = 0;
          if (o_awvalid) proto_err++;
        end
        if (o_wvalid) w_hi++;
        if (o_wvalid && !w_got) begin
          if (w_wait >= w_d) begin
            i_wready = 1; w_got = 1; w_hs++; seen_wdata = o_wdata; seen_wstrb = o_wstrb;
          end else begin i_wready = 0; w_wait++; end
        end else begin
          i_wready = 0;
          if (o_wvalid) proto_err++;
        end
        if (o_arvalid) ar_hi++;
        if (o_arvalid && !ar_got) begin
          if (ar_wait >= ar_d) begin
            i_arready = 1; ar_got = 1; ar_hs++; seen_araddr = o_araddr;
          end else begin i_arready = 0; ar_wait++; end
        end else begin
          i_arready = 0;
          if (o_arvalid) proto_err++;
        end
      end
    end
  end

  task automatic arm(input vec_t v);
    aw_d = v.awd; w_d = v.wd; b_d = v.bd; ar_d = v.ard; r_d = v.rd;
    s_rdata = v.rdata; s_rresp = v.rresp; s_bresp = v.bresp;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    seen_awaddr = 'x; seen_araddr = 'x; seen_wdata = 'x; seen_wstrb = 'x;
  endtask

  // Reference: response content and cycle latency from the timing rules.
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    int mx = (v.awd > v.wd) ? v.awd : v.wd;
    m.exp_resp  = v.wr ? v.bresp : v.rresp;
    m.exp_data  = v.wr ? 32'h0 : v.rdata;
    m.exp_lat   = v.wr ? 3 + mx + v.bd : 3 + v.ard + v.rd;
    m.exp_aw_hi = v.wr ? v.awd + 1 : 0;
    m.exp_w_hi  = v.wr ? v.wd + 1 : 0;
    return m;
  endfunction

  task automatic run_txn(input bit wr, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, output int lat,
                         output logic [31:0] r_data, output logic [1:0] r_resp,
                         output logic r_write, output logic r_to);
    int t;
    int unsigned a_cyc;
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = a; i_cmd_data = d; i_cmd_strb = s;
    t = 0;
    while (!o_cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_accept_bound", 64'(t < 50), 64'd1);
    a_cyc = cyc;
    @(negedge clk);
    i_cmd_valid = 0;
    t = 0;
    while (!o_rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("rsp_wait_bound", 64'(t < 100), 64'd1);
    lat = int'(cyc - a_cyc);
    r_data = o_rsp_data; r_resp = o_rsp_resp; r_write = o_rsp_write; r_to = o_rsp_timeout;
    for (int k = 0; k < hold; k++) begin
      chk("rsp_hold_stable", {o_rsp_valid, o_rsp_data, o_rsp_resp, o_rsp_write, o_rsp_timeout},
          {1'b1, r_data, r_resp, r_write, r_to});
      chk("cmd_ready_during_rsp", o_cmd_ready, 0);
      @(negedge clk);
    end
    i_rsp_ready = 1;
    @(negedge clk);
    i_rsp_ready = 0;
    chk("rsp_valid_drop", o_rsp_valid, 0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    logic [31:0] rd;
    logic [1:0] rr;
    logic rw, rt;
    arm(v);
    run_txn(v.wr, v.addr, v.data, v.strb, v.hold, lat, rd, rr, rw, rt);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " rsp_data"}, rd, v.exp_data);
    chk({tag, " rsp_resp"}, rr, v.exp_resp);
    chk({tag, " rsp_write"}, rw, v.wr);
    chk({tag, " rsp_timeout"}, rt, 0);
    if (v.wr) begin
      chk({tag, " awaddr"}, seen_awaddr, v.addr);
      chk({tag, " wdata"}, seen_wdata, v.data);
      chk({tag, " wstrb"}, seen_wstrb, v.strb);
      chk({tag, " awvalid_cycles"}, aw_hi, v.exp_aw_hi);
      chk({tag, " wvalid_cycles"}, w_hi, v.exp_w_hi);
      chk({tag, " b_beats"}, b_hs, 1);
      chk({tag, " ar_beats"}, ar_hs, 0);
    end else begin
      chk({tag, " araddr"}, seen_araddr, v.addr);
      chk({tag, " r_beats"}, r_hs, 1);
      chk({tag, " aw_beats"}, aw_hs, 0);
    end
    chk({tag, " protocol"}, proto_err, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ctrl_outs"}, {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
        o_rsp_valid, o_hung, o_rsp_timeout, o_rsp_write, o_rsp_resp}, 0);
    chk({tag, " data_outs"}, {o_awaddr, o_araddr, o_wdata, o_wstrb, o_rsp_data}, 0);
    chk({tag, " cmd_ready_in_rst"}, o_cmd_ready, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    vec_t rv;
    int lat, t;
    logic [31:0] rd;
    logic [1:0] rr;
    logic rw, rt;

    // wr addr data strb | awd wd bd ard rd | rdata rresp bresp hold | exp_resp exp_data lat aw_hi w_hi
    vt[0] = '{1'b1, 16'h0000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 2'b00, 32'h0, 3, 1, 1};
    vt[1] = '{1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h10000000, 2'b00, 2'b00, 0, 2'b00, 32'h10000000, 3, 0, 0};
    vt[2] = '{1'b1, 16'h0010, 32'hCAFEF00D, 4'h3, 3, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 2'b00, 32'h0, 6, 4, 1};
    vt[3] = '{1'b0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h12345678, 2'b10, 2'b00, 5, 2'b10, 32'h12345678, 3, 0, 0};
    vt[4] = '{1'b1, 16'h0020, 32'h55AA55AA, 4'hC, 0, 2, 1, 0, 0, 32'h0, 2'b00, 2'b10, 1, 2'b10, 32'h0, 6, 1, 3};
    vt[5] = '{1'b0, 16'h00FC, 32'h0, 4'h0, 0, 0, 0, 2, 3, 32'hA5A50001, 2'b11, 2'b00, 0, 2'b11, 32'hA5A50001, 8, 0, 0};

    rst = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_data = 0;
    i_cmd_strb = 0; i_rsp_ready = 0;
    arm(vt[0]);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    chk("cmd_ready_after_reset", o_cmd_ready, 1);

    for (int i = 0; i < 6; i++) apply(vt[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      rv.wr = 1'($urandom_range(0, 1));
      rv.addr = 16'($urandom) & 16'hFFFC;
      rv.data = $urandom;
      rv.strb = 4'($urandom_range(1, 15));
      rv.awd = $urandom_range(0, 3); rv.wd = $urandom_range(0, 3); rv.bd = $urandom_range(0, 3);
      rv.ard = $urandom_range(0, 3); rv.rd = $urandom_range(0, 3);
      rv.rdata = $urandom; rv.rresp = 2'($urandom); rv.bresp = 2'($urandom);
      rv.hold = $urandom_range(0, 2);
      rv = model(rv);
      apply(rv, $sformatf("rnd%0d", i));
    end

    // rst while waiting for the B beat
    rv = vt[0];
    rv.bd = 1000;
    arm(rv);
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = 16'h0040; i_cmd_data = 32'h01020304; i_cmd_strb = 4'hF;
    t = 0;
    while (!o_cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    i_cmd_valid = 0;
    t = 0;
    while (!o_bready && t < 20) begin @(negedge clk); t++; end
    chk("wr_b_reached", o_bready, 1);
    rst = 1;
    @(negedge clk);
    chk_reset_outputs("rst_in_wr_b");
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", o_rsp_valid, 0);
    end
    chk("cmd_ready_after_mid_rst", o_cmd_ready, 1);

    // watchdog: arready never arrives
    rv = vt[1];
    rv.ard = 1000;
    arm(rv);
    run_txn(1'b0, 16'h0080, 32'h0, 4'h0, 2, lat, rd, rr, rw, rt);
    chk("to latency", lat, TO + 1);
    chk("to arvalid_cycles", ar_hi, TO);
    chk("to arvalid_low", o_arvalid, 0);
    chk("to rsp_resp", rr, 2'b11);
    chk("to rsp_timeout", rt, 1);
    chk("to rsp_data", rd, 0);
    chk("to hung", o_hung, 1);
    i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = 16'h0004; i_cmd_data = 32'h1; i_cmd_strb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hung cmd_ready", o_cmd_ready, 0);
      chk("hung axi_outs", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid}, 0);
    end
    i_cmd_valid = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("hung cleared", o_hung, 0);
    chk("cmd_ready restored", o_cmd_ready, 1);
    apply(vt[0], "post_hung");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Converts a simple one-command-at-a-time request/response interface into AXI4-Lite master transactions. It sits directly upstream of the AXI-Lite register slaves in this core family, such as the demo register blocks. It lets a sequencer, debug UART bridge or testbench issue register reads and writes without handling the five AXI channels itself. It has at most one transaction outstanding and an optional hang watchdog.

## Interface
Parameters:
- ADDR_WIDTH, 16, AXI and command address width
- TIMEOUT_CYCLES, 256, max cycles a transaction may stay in flight; 0 disables the watchdog

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_WIDTH  byte address
- i_cmd_data  in  32  write data
- i_cmd_strb  in  4  write byte strobes
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed
- o_rsp_write  out  1  response belongs to a write
- o_rsp_data  out  32  read data; 0 for writes
- o_rsp_resp  out  2  AXI resp (00 OKAY, 10 SLVERR, 11 DECERR/timeout)
- o_rsp_timeout  out  1  response was generated by the watchdog
- o_hung  out  1  sticky: watchdog fired, block frozen until rst
- o_awvalid/i_awready/o_awaddr[ADDR_WIDTH]  AXI write address channel
- o_wvalid/i_wready/o_wdata[32]/o_wstrb[4]  AXI write data channel
- i_bvalid/o_bready/i_bresp[2]  AXI write response channel
- o_arvalid/i_arready/o_araddr[ADDR_WIDTH]  AXI read address channel
- i_rvalid/o_rready/i_rdata[32]/i_rresp[2]  AXI read data channel

## Operation
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP, HUNG.
- IDLE: o_cmd_ready = (state==IDLE) && !rst. On accept, latch addr/data/strb/write and clear the watchdog counter.
  - Write: go to WR_AW_W.
  - Read: go to RD_AR.
- WR_AW_W: o_awvalid and o_wvalid are both high from state entry.
  - Each valid drops independently on its own handshake.
  - The state exits to WR_B once both handshakes are done; both may occur in the same cycle or in either order.
- WR_B: o_bready high. On i_bvalid, capture i_bresp, set o_rsp_data=0 and go to RSP.
- RD_AR: o_arvalid high until i_arready, then go to RD_R.
- RD_R: o_rready high. On i_rvalid, capture i_rdata/i_rresp and go to RSP.
- RSP: o_rsp_valid high and all response fields stable until i_rsp_ready. Then go to IDLE, or to HUNG if o_rsp_timeout is set.
- Valids are never withdrawn before their handshake, except by watchdog or rst.
- B and R beats outside WR_B/RD_R are ignored; o_bready and o_rready are low there.
- Watchdog (TIMEOUT_CYCLES>0): the counter increments each cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When the count reaches TIMEOUT_CYCLES without the awaited completion, drop all AXI valids and readies.
  - Set o_rsp_resp=11, o_rsp_timeout=1, o_rsp_data=0, o_hung=1, and go to RSP.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - A completion in the same cycle as the limit wins; no timeout is reported.
- HUNG: o_cmd_ready=0 and all AXI outputs low until rst. This is required because a hung AXI transaction cannot legally be resumed.

## Timing
- All outputs are registered except o_cmd_ready, which is decoded from state.
- Reset: state IDLE. Every valid and ready output is 0, o_cmd_ready is 0 while rst is high, o_hung=0, and all data/addr/resp outputs are 0.
- Command accepted at edge N:
  - AXI valids high in cycle N+1.
  - With zero-wait slave handshakes, o_bready/o_rready is high in cycle N+2.
  - With the response beat in cycle N+2, o_rsp_valid is high in cycle N+3.
  - Minimum command-to-response latency is 3 cycles.
- The next command is accepted no earlier than the cycle after the o_rsp_valid && i_rsp_ready handshake.
- rst mid-transaction: everything returns to reset values on the next edge, with no response emitted.

## Test plan
- Write 0x0000 = 0xDEADBEEF, strb F; slave ready immediately, bvalid in the first WR_B cycle.
  - AXI sees awaddr=0, wdata=0xDEADBEEF, wstrb=F.
  - o_rsp_valid 3 cycles after accept, with resp=00, write=1, data=0.
- Read 0x0004 from a slave returning 0x10000000/OKAY.
  - o_rsp_data=0x10000000, resp=00, write=0, latency 3 cycles.
- Write with awready delayed 3 cycles and wready immediate.
  - o_wvalid drops after 1 cycle; o_awvalid is held 4 cycles.
  - o_bready only after the AW handshake; exactly one response.
- Read 0x0008 with the slave answering rresp=10 and i_rsp_ready held low 5 cycles.
  - Response is held stable for 5 cycles with resp=10.
  - o_cmd_ready stays 0 until the handshake.
- TIMEOUT_CYCLES=16, slave never asserts arready.
  - After 16 cycles in RD_AR: o_arvalid=0, response resp=11, timeout=1.
  - o_hung=1 and the next command is not accepted; rst clears o_hung and restores o_cmd_ready=1.
- Assert rst during WR_B.
  - Next cycle all outputs are at reset values, and no o_rsp_valid is generated.
